uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (start/8 data/parity/stop framing, 8x oversampled) among N requesters.
- Uses round-robin arbitration. Per frame: accept one byte, launch the transmitter, wait for its completion, enforce an inter-frame idle gap.
- Detects a hung transmitter with a timeout.
- Sits between the client logic and the UART transmit engine, in the top-level UART wrapper.

Parameters:
- N, 4, number of requesters (2..8).
- GAP_CYCLES, 16, clk cycles of enforced idle after each frame completes (0 = no gap).
- TIMEOUT_CYCLES, 1024, max clk cycles in WAIT before abort (must be > one frame time, 11 bits x 8 clk).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  N  per-requester request, level; held until granted
- req_data  in  8*N  byte for requester i at bits [8i+7:8i]
- gnt  out  N  one-hot, one-cycle pulse: request i accepted, data captured
- tx_ready  in  1  transmitter idle and able to accept a start
- tx_start  out  1  one-cycle launch pulse to transmitter
- tx_data  out  8  byte to transmit; stable from LAUNCH until the next grant
- tx_done  in  1  one-cycle pulse from transmitter after stop bit
- busy  out  1  high in any state other than IDLE
- active_id  out  $clog2(N)  index of the requester currently being served
- err_timeout  out  1  one-cycle pulse when a WAIT times out

Behaviour:
- Reset values:
  - gnt=0, tx_start=0, tx_data=0, busy=0, active_id=0, err_timeout=0.
  - state=IDLE, last_id=N-1 so requester 0 has first priority.
  - Gap and timeout counters = 0.
- Reset is synchronous and aborts any state. tx_start is never asserted in the cycle after rst is sampled high.
- State machine: IDLE, LAUNCH, WAIT, GAP. All outputs are registered.
- IDLE:
  - Arbitrates on the edge where |req && tx_ready.
  - Winner is the first asserted req searching from (last_id+1) mod N upward, with wrap-around.
  - On that edge: gnt[winner]=1 for exactly one cycle, tx_data<=req_data[winner], active_id<=winner, last_id<=winner, go to LAUNCH.
  - If tx_ready=0, no grant; stay in IDLE.
- LAUNCH: tx_start=1 for exactly one cycle, clear timeout counter, go to WAIT. Grant-to-tx_start latency is 1 cycle: gnt is visible in cycle k, tx_start in cycle k+1.
- WAIT:
  - Increments the timeout counter each cycle.
  - tx_done=1: go to GAP, or to IDLE if GAP_CYCLES=0.
  - Counter reaches TIMEOUT_CYCLES-1 with no tx_done: err_timeout=1 for one cycle, then the same transition as tx_done.
  - tx_done has priority over timeout in the same cycle, and no error is flagged.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to IDLE.
  - With the 1-cycle IDLE arbitration, the next tx_start comes no earlier than GAP_CYCLES+2 cycles after tx_done.
- tx_done pulses outside WAIT are ignored.
- A req deasserted before grant is simply not served; no state is kept.
- A requester still holding req after its gnt is treated as a new request. It is served again only after every other pending requester has had a turn.
- busy=1 in LAUNCH, WAIT and GAP; 0 in IDLE.
- Only one frame is in flight at a time. No buffering beyond the tx_data register.

Test Plan:
- Reset, then req=0001, data0=0xA5, tx_ready=1 -> gnt=0001 one cycle later; tx_start next cycle with tx_data=0xA5; busy=1 until GAP expires 16 cycles after tx_done.
- req=1111 held continuously, with a transmitter model (done 88 cycles after start) -> grant order 0,1,2,3,0; each gnt is one-hot; tx_start pulses are spaced >= 88+16+2 cycles.
- last_id=2, req=0011 -> requester 0 granted (wrap-around), then requester 1.
- tx_ready=0 with req=0100 -> no gnt, no tx_start; raising tx_ready -> gnt=0100 on the next edge.
- Model never returns tx_done, TIMEOUT_CYCLES=1024 -> err_timeout pulses once 1024 cycles after entering WAIT; FSM reaches IDLE after the gap.
- rst asserted mid-WAIT -> next cycle all outputs at reset values; next arbitration favours requester 0; a stale tx_done after reset causes no transition.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N requesters
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   req[N]       per-requester request level, held until granted
//   req_data[8N] byte for requester i at [8i+7:8i]
//   gnt[N]       one-hot single-cycle grant, data captured
//   tx_ready     transmitter idle and able to start
//   tx_start     single-cycle launch pulse
//   tx_data[8]   byte being transmitted, held until the next grant
//   tx_done      single-cycle completion pulse from the transmitter
//   busy         high whenever a frame or its idle gap is in progress
//   active_id    index of the requester being served
//   err_timeout  single-cycle pulse when the transmitter fails to finish
module uart_tx_arbiter #(
    parameter int N              = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [8*N-1:0]       req_data,
    output logic [N-1:0]         gnt,
    input  logic                 tx_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [$clog2(N)-1:0] active_id,
    output logic                 err_timeout
);

    localparam int IDW = $clog2(N);
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] last_id, last_id_nx;
    logic [IDW-1:0] winner;
    logic           found;
    logic [GW-1:0]  gap_cnt, gap_cnt_nx;
    logic [TW-1:0]  tmo_cnt, tmo_cnt_nx;

    logic [N-1:0]   gnt_nx;
    logic           tx_start_nx;
    logic [7:0]     tx_data_nx;
    logic [IDW-1:0] active_id_nx;
    logic           err_nx;
    logic           busy_nx;

    // Walk the distances N..1 from last_id so the closest requester after
    // last_id is the final (winning) assignment; distance N is last_id itself,
    // which therefore only wins when nobody else is asking.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last_id) + i) % N]) begin
                winner = IDW'((int'(last_id) + i) % N);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        last_id_nx   = last_id;
        gap_cnt_nx   = gap_cnt;
        tmo_cnt_nx   = tmo_cnt;
        gnt_nx       = '0;
        tx_start_nx  = 1'b0;
        tx_data_nx   = tx_data;
        active_id_nx = active_id;
        err_nx       = 1'b0;
        case (state)
            S_IDLE: begin
                if (found && tx_ready) begin
                    gnt_nx       = N'(1) << winner;
                    tx_data_nx   = req_data[8*winner +: 8];
                    active_id_nx = winner;
                    last_id_nx   = winner;
                    state_nx     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start_nx = 1'b1;
                tmo_cnt_nx  = '0;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the last allowed cycle still counts
                // as a normal finish, so the error is only raised without it.
                if (tx_done || (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
                    err_nx     = !tx_done;
                    gap_cnt_nx = '0;
                    state_nx   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_nx = S_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + GW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_id     <= IDW'(N - 1);
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            gnt         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            active_id   <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            last_id     <= last_id_nx;
            gap_cnt     <= gap_cnt_nx;
            tmo_cnt     <= tmo_cnt_nx;
            gnt         <= gnt_nx;
            tx_start    <= tx_start_nx;
            tx_data     <= tx_data_nx;
            active_id   <= active_id_nx;
            err_timeout <= err_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 16;
    localparam int TMO = 1024;
    localparam int FRM = 88;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           tx_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    logic [1:0]     active_id;
    logic           err_timeout;

    logic xm_ready = 1'b1;
    logic xm_done = 1'b0;
    logic xm_hang = 1'b0;
    logic stim_ready_low = 1'b0;
    logic stim_done = 1'b0;
    int   xm_cnt = 0;

    assign tx_ready = xm_ready & ~stim_ready_low;
    assign tx_done  = xm_done | stim_done;

    uart_tx_arbiter #(.N(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .active_id(active_id),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Round-robin winner = requester at the smallest forward distance past last.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int best;
        int bd;
        best = -1;
        bd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int d;
                d = (i - last - 1 + 2 * N) % N;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // Timeline model: edge numbers of grant, end of frame and return to idle.
    logic         m_live = 1'b0;
    logic         m_inflight = 1'b0;
    int           m_g = -10;
    int           m_end = 0;
    int           m_idle_from = 0;
    int           m_last = N - 1;
    logic [N-1:0] e_gnt = '0;
    logic         e_start = 1'b0;
    logic [7:0]   e_data = 8'h00;
    logic         e_busy = 1'b0;
    logic [1:0]   e_id = '0;
    logic         e_err = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_live = 1'b1;
                m_inflight = 1'b0;
                m_g = -10;
                m_idle_from = cyc;
                m_last = N - 1;
                e_gnt = '0;
                e_start = 1'b0;
                e_err = 1'b0;
                e_data = 8'h00;
                e_id = '0;
                e_busy = 1'b0;
            end else begin
                e_gnt = '0;
                e_err = 1'b0;
                e_start = m_inflight && (cyc == m_g + 1);
                if (m_inflight && cyc >= m_g + 2) begin
                    if (tx_done) begin
                        m_inflight = 1'b0;
                        m_end = cyc;
                    end else if (cyc == m_g + 1 + TMO) begin
                        e_err = 1'b1;
                        m_inflight = 1'b0;
                        m_end = cyc;
                    end
                    if (!m_inflight) m_idle_from = m_end + GAP;
                end else if (!m_inflight && cyc > m_idle_from && req != 0 && tx_ready) begin
                    int w;
                    w = rr_pick(req, m_last);
                    e_gnt[w] = 1'b1;
                    e_data = req_data[8*w +: 8];
                    e_id = 2'(w);
                    m_last = w;
                    m_g = cyc;
                    m_inflight = 1'b1;
                end
                e_busy = m_inflight || (cyc < m_idle_from);
            end
        end
    end

    // Transmitter model: completes FRM cycles after each start unless hung.
    initial begin
        forever begin
            @(negedge clk);
            xm_done = 1'b0;
            if (rst) begin
                xm_cnt = 0;
                xm_ready = 1'b1;
            end else if (tx_start) begin
                xm_ready = 1'b0;
                xm_cnt = xm_hang ? 0 : FRM;
            end else if (xm_cnt > 0) begin
                xm_cnt--;
                if (xm_cnt == 0) begin
                    xm_done = 1'b1;
                    xm_ready = 1'b1;
                end
            end
        end
    end

    int   gnt_log[$];
    int   start_log[$];
    int   err_log[$];
    int   busy_fall = 0;
    logic prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("gnt", gnt, e_gnt);
                check("tx_start", tx_start, e_start);
                check("tx_data", tx_data, e_data);
                check("busy", busy, e_busy);
                check("active_id", active_id, e_id);
                check("err_timeout", err_timeout, e_err);
                if (gnt != 0) begin
                    int gi;
                    gi = 0;
                    check("gnt_onehot", $onehot(gnt), 1);
                    for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
                    gnt_log.push_back(gi);
                end
                if (tx_start) start_log.push_back(cyc);
                if (err_timeout) err_log.push_back(cyc);
                if (prev_busy && !busy) busy_fall = cyc;
                prev_busy = busy;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < maxc) begin
            tick(1);
            k++;
        end
        check(name, busy, 0);
    endtask

    task automatic hold_until_grant(input string name, input int maxc);
        int k;
        logic seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < maxc) begin
            tick(1);
            k++;
            if (gnt != 0) begin
                seen = 1'b1;
                req = req & ~gnt;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n0;
        int s0;
        int e0;
        int k;

        // Reset state and a single frame from requester 0.
        tick(2);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_active_id", active_id, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_err", err_timeout, 0);
        rst = 1'b0;
        req_data = 32'h0000_00A5;
        req = 4'b0001;
        tick(1);
        check("t1_gnt", gnt, 4'b0001);
        req = '0;
        tick(1);
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 8'hA5);
        wait_idle("t1_idle", 300);
        check("t1_gap", busy_fall - m_end, 16);

        // All four held: order 0,1,2,3,0 with frames spaced by frame+gap+2.
        pulse_reset();
        gnt_log.delete();
        start_log.delete();
        req_data = 32'h4332_2110;
        req = 4'b1111;
        k = 0;
        while (gnt_log.size() < 5 && k < 1000) begin
            tick(1);
            k++;
        end
        check("t2_grant_count", gnt_log.size(), 5);
        req = '0;
        tick(1);
        for (int i = 0; i < 5; i++) check("t2_order", gnt_log[i], exp_order[i]);
        for (int i = 1; i < start_log.size(); i++)
            check("t2_spacing", (start_log[i] - start_log[i-1]) >= FRM + GAP + 2, 1);
        wait_idle("t2_idle", 300);

        // last_id=2 then req=0011: wrap-around to 0, then 1.
        req = 4'b0100;
        hold_until_grant("t3_grant2", 50);
        wait_idle("t3_idle_a", 300);
        gnt_log.delete();
        req = 4'b0011;
        hold_until_grant("t3_grant_a", 50);
        hold_until_grant("t3_grant_b", 300);
        wait_idle("t3_idle_b", 300);
        check("t3_first", gnt_log[0], 0);
        check("t3_second", gnt_log[1], 1);

        // Transmitter not ready: no grant until tx_ready rises.
        stim_ready_low = 1'b1;
        req = 4'b0100;
        n0 = gnt_log.size();
        s0 = start_log.size();
        tick(6);
        check("t4_no_gnt", gnt_log.size(), n0);
        check("t4_no_start", start_log.size(), s0);
        stim_ready_low = 1'b0;
        tick(1);
        check("t4_gnt", gnt, 4'b0100);
        req = '0;
        wait_idle("t4_idle", 300);

        // Hung transmitter: one timeout pulse 1024 cycles into WAIT, then gap.
        xm_hang = 1'b1;
        req = 4'b0001;
        e0 = err_log.size();
        hold_until_grant("t5_grant", 50);
        k = 0;
        while (err_log.size() == e0 && k < 1200) begin
            tick(1);
            k++;
        end
        check("t5_err_seen", err_log.size(), e0 + 1);
        check("t5_err_latency", err_log[$] - start_log[$], 1024);
        wait_idle("t5_idle", 100);
        check("t5_gap", busy_fall - err_log[$], 16);
        tick(4);
        check("t5_err_once", err_log.size(), e0 + 1);
        xm_hang = 1'b0;
        pulse_reset();

        // Reset in WAIT, stale tx_done ignored, requester 0 favoured again.
        req = 4'b0010;
        hold_until_grant("t6_grant", 50);
        tick(5);
        rst = 1'b1;
        tick(1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_start", tx_start, 0);
        check("t6_rst_data", tx_data, 0);
        check("t6_rst_id", active_id, 0);
        rst = 1'b0;
        stim_done = 1'b1;
        tick(1);
        stim_done = 1'b0;
        check("t6_stale_a", busy, 0);
        tick(1);
        check("t6_stale_b", busy, 0);
        gnt_log.delete();
        req = 4'b1001;
        hold_until_grant("t6_grant_b", 50);
        req = '0;
        check("t6_first", gnt_log[0], 0);
        wait_idle("t6_idle", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
